// File: rtl/serv_dbus_responder.sv
// Wishbone-style data-bus responder for the SERV core, backed by a word-wide RAM with byte enables.
// Optional per-access stall cycles are compiled in with the SERV_RSP_WAIT_EN macro.
module serv_dbus_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack
);
    localparam int AW = $clog2(DEPTH);

`ifdef SERV_RSP_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);
    logic [3:0] cnt_reg, cnt_next;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd2} state_t;
`endif

    state_t      state_reg, state_next;
    logic        enter_ack;
    logic [31:0] rdt_reg;
    logic        ack_reg;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic        in_range;
    logic        unused_bits;

    assign word_idx    = i_wb_adr[AW+1:2];
    assign in_range    = (i_wb_adr[31:AW+2] == '0);
    assign unused_bits = ^{i_wb_adr[1:0], WAIT_CYCLES[0]};
    assign o_wb_rdt    = rdt_reg;
    assign o_wb_ack    = ack_reg;

    always_comb begin
        state_next = state_reg;
        enter_ack  = 1'b0;
`ifdef SERV_RSP_WAIT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_wb_cyc) begin
`ifdef SERV_RSP_WAIT_EN
                    if (USE_WAIT) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_CYCLES[3:0];
                    end else begin
                        state_next = ACK;
                        enter_ack  = 1'b1;
                    end
`else
                    state_next = ACK;
                    enter_ack  = 1'b1;
`endif
                end
            end
`ifdef SERV_RSP_WAIT_EN
            WAIT: begin
                if (!i_wb_cyc) begin
                    // Master withdrew the request: abandon without touching RAM.
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = ACK;
                    enter_ack  = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next   = cnt_reg - 4'd1;
                end
            end
`endif
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            rdt_reg   <= 32'd0;
`ifdef SERV_RSP_WAIT_EN
            cnt_reg   <= 4'd0;
`endif
        end else begin
            state_reg <= state_next;
            ack_reg   <= enter_ack;
`ifdef SERV_RSP_WAIT_EN
            cnt_reg   <= cnt_next;
`endif
            // Read returns the pre-write word; writes leave the read register untouched.
            if (enter_ack && !i_wb_we)
                rdt_reg <= in_range ? mem[word_idx] : 32'd0;
        end
    end

    // RAM is deliberately outside the reset domain so its contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (enter_ack && i_wb_we && in_range && !i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b])
                    mem[word_idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_serv_dbus_responder.sv
// Directed self-checking bench for serv_dbus_responder (latency expectations follow SERV_RSP_WAIT_EN).
module tb_serv_dbus_responder;
    localparam int WAITS = 2;
`ifdef SERV_RSP_WAIT_EN
    localparam int LAT = WAITS + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        cyc = 1'b0;
    logic [31:0] rdt;
    logic        ack;

    int checks   = 0;
    int failures = 0;

    serv_dbus_responder #(.DEPTH(256), .WAIT_CYCLES(WAITS)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack)
    );

    always #5 clk = ~clk;

    // One bus transaction; lat = cycles from request to ack (0 = timed out).
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
        @(negedge clk);
        we = w; adr = a; dat = d; sel = s; cyc = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                break;
            end
        end
        cyc = 1'b0;
        $display("xfer we=%0b adr=%08h dat=%08h sel=%04b lat=%0d rdt=%08h", w, a, d, s, lat, rdt);
        @(posedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", ack); end
        checks++;
        if (rdt !== 32'd0) begin failures++; $display("FAIL reset_rdt got=%08h exp=00000000", rdt); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL basic_wr_lat got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (rdt !== 32'd0) begin failures++; $display("FAIL basic_wr_rdt_hold got=%08h exp=00000000", rdt); end
        xfer(1'b0, 32'h10, 32'h0, 4'hF, lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL basic_rd_lat got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (rdt !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%08h exp=deadbeef", rdt); end
    endtask

    task automatic test_byte_merge;
        int lat;
        xfer(1'b1, 32'h8, 32'h11223344, 4'b1111, lat);
        xfer(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, lat);
        checks++;
        if (rdt !== 32'hDEADBEEF) begin failures++; $display("FAIL merge_rdt_hold got=%08h exp=deadbeef", rdt); end
        xfer(1'b0, 32'h8, 32'h0, 4'hF, lat);
        checks++;
        if (rdt !== 32'h11BB33DD) begin failures++; $display("FAIL merge_rd got=%08h exp=11bb33dd", rdt); end
        xfer(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL sel0_lat got=%0d exp=%0d", lat, LAT); end
        xfer(1'b0, 32'h8, 32'h0, 4'hF, lat);
        checks++;
        if (rdt !== 32'h11BB33DD) begin failures++; $display("FAIL sel0_rd got=%08h exp=11bb33dd", rdt); end
    endtask

    task automatic test_out_of_range;
        int lat;
        xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat);
        xfer(1'b1, 32'h400, 32'h12345678, 4'hF, lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL oor_wr_lat got=%0d exp=%0d", lat, LAT); end
        xfer(1'b0, 32'h400, 32'h0, 4'hF, lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL oor_rd_lat got=%0d exp=%0d", lat, LAT); end
        checks++;
        if (rdt !== 32'd0) begin failures++; $display("FAIL oor_rd got=%08h exp=00000000", rdt); end
        xfer(1'b0, 32'h0, 32'h0, 4'hF, lat);
        checks++;
        if (rdt !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_alias got=%08h exp=cafef00d", rdt); end
    endtask

    task automatic test_back_to_back;
        int first, gap;
        @(negedge clk);
        we = 1'b0; adr = 32'h10; sel = 4'hF; cyc = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin first = i; break; end
        end
        checks++;
        if (first !== LAT) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=%0d", first, LAT); end
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL b2b_pulse got=%0b exp=0", ack); end
        gap = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin gap = i; break; end
        end
        $display("b2b held read first_lat=%0d gap=%0d rdt=%08h", first, gap, rdt);
        checks++;
        if (gap !== LAT + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, LAT + 1); end
        checks++;
        if (rdt !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_rd got=%08h exp=deadbeef", rdt); end
        // Still inside the ACK cycle: reset must drop everything immediately.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL rst_in_ack got=%0b exp=0", ack); end
        checks++;
        if (rdt !== 32'd0) begin failures++; $display("FAIL rst_rdt got=%08h exp=00000000", rdt); end
        cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, 4'hF, gap);
        checks++;
        if (rdt !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_survives_rst got=%08h exp=deadbeef", rdt); end
    endtask

`ifdef SERV_RSP_WAIT_EN
    task automatic test_abort;
        int lat;
        logic seen;
        xfer(1'b1, 32'h20, 32'h00000055, 4'hF, lat);
        @(negedge clk);
        we = 1'b1; adr = 32'h20; dat = 32'h00000099; sel = 4'hF; cyc = 1'b1;
        @(negedge clk);
        cyc = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        $display("abort write adr=00000020 ack_seen=%0b", seen);
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_ack got=%0b exp=0", seen); end
        xfer(1'b0, 32'h20, 32'h0, 4'hF, lat);
        checks++;
        if (rdt !== 32'h00000055) begin failures++; $display("FAIL abort_ram got=%08h exp=00000055", rdt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_merge();
        test_out_of_range();
        test_back_to_back();
`ifdef SERV_RSP_WAIT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serv_dbus_responder.md
SERV_DBUS_RESPONDER -- requirements
Module: serv_dbus_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words of backing RAM (power of two, 4..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra stall cycles per access when SERV_RSP_WAIT_EN is defined (0..15).
REQ-003 SHALL have port i_clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_wb_adr  input  32  byte address from the core's data bus; bits [1:0] ignored.
REQ-006 SHALL have port i_wb_dat  input  32  write data.
REQ-007 SHALL have port i_wb_sel  input  4  byte enables; bit n selects dat[8n+7:8n].
REQ-008 SHALL have port i_wb_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port i_wb_cyc  input  1  request valid, held until ack.
REQ-010 SHALL have port o_wb_rdt  output  32  read data, registered.
REQ-011 SHALL have port o_wb_ack  output  1  single-cycle completion pulse, registered.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-013 IDLE -> ACK when i_wb_cyc is sampled high and WAIT_CYCLES = 0 or the macro is absent; IDLE -> WAIT when i_wb_cyc is high, the macro is present and WAIT_CYCLES > 0; otherwise stay in IDLE.
REQ-014 WAIT SHALL load a down-counter with WAIT_CYCLES on entry and go to ACK on the edge where the counter reaches 0 with i_wb_cyc still high.
REQ-015 i_wb_cyc low in WAIT SHALL abort: return to IDLE, no RAM write, no ack.
REQ-016 ACK SHALL last exactly one cycle with o_wb_ack = 1, then return to IDLE unconditionally, even if i_wb_cyc is still high; a new request is sampled no earlier than the following cycle.
REQ-017 o_wb_ack SHALL be 1 only in ACK.
REQ-018 Word index SHALL be i_wb_adr[log2(DEPTH)+1:2]; an address is in range when i_wb_adr[31:log2(DEPTH)+2] = 0.
REQ-019 A write SHALL update only the selected bytes, on the edge that enters ACK; sel = 0000 SHALL still ack with no change.
REQ-020 A read SHALL load o_wb_rdt on the edge that enters ACK with the word content before any same-edge write; o_wb_rdt SHALL hold its value at all other times, including on writes.
REQ-021 An out-of-range read SHALL return 0x00000000; an out-of-range write SHALL be dropped; both SHALL ack normally.
REQ-022 Latency from i_wb_cyc sampled high to o_wb_ack SHALL be 1 cycle without the macro, and WAIT_CYCLES+1 cycles with it.
REQ-023 i_wb_adr, i_wb_dat, i_wb_sel and i_wb_we SHALL be sampled on the ack-entering edge; changes during WAIT are honoured.

Reset
REQ-024 i_rst high SHALL immediately force state IDLE, o_wb_ack = 0, o_wb_rdt = 0 and the wait counter = 0.
REQ-025 Reset during WAIT or ACK SHALL complete no transfer; RAM contents SHALL NOT be reset.
REQ-026 After i_rst deasserts, the first request SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro SERV_RSP_WAIT_EN defined: WAIT state and counter present, per REQ-013/014/015/022.
REQ-028 SERV_RSP_WAIT_EN undefined: no WAIT state or counter logic, WAIT_CYCLES ignored, fixed 1-cycle latency.

Verification
REQ-029 Macro off: write adr 0x10, dat 0xDEADBEEF, sel 1111; read 0x10 -> ack 1 cycle after cyc each time, rdt = 0xDEADBEEF.
REQ-030 Byte merge: write 0x11223344 sel 1111, then 0xAABBCCDD sel 0101 to adr 0x8; read 0x8 -> 0x11BB33DD.
REQ-031 Macro on, WAIT_CYCLES=2: read -> ack exactly 3 cycles after cyc sampled high; drop cyc after 1 cycle of a write -> no ack, RAM unchanged.
REQ-032 DEPTH=256: read adr 0x400 -> rdt 0, ack; write 0x400 -> aliased word 0x0 unchanged.
REQ-033 cyc held high across ack -> ack is a single-cycle pulse, next ack no earlier than 2 cycles later; assert i_rst in ACK -> ack drops the same cycle, rdt = 0.
